// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: sequencer state encoding
// used by the control FSM, the datapath and benches for state display.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/step_counter.sv
// RUN step counter: clears on clr, counts on en, and wraps to zero after the
// terminal count so it never exceeds Word_Length-1.
module step_counter #(
    parameter int  Word_Length = 8,
    localparam int CNT_W       = (Word_Length > 1) ? $clog2(Word_Length) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(Word_Length - 1);

    assign term = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            // Wrap on terminal count: works for non-power-of-2 lengths
            count <= term ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the shift-and-add sequential multiplier: IDLE -> LOAD ->
// Word_Length RUN steps -> DONE, held until ack. Outputs are Moore except add_en.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int  Word_Length = 8,
    localparam int CNT_W       = (Word_Length > 1) ? $clog2(Word_Length) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             mplr_lsb,
    output logic             load_regs,
    output logic             add_en,
    output logic             shift_en,
    output logic [CNT_W-1:0] step,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    mult_state_t state, state_nxt;
    logic        cnt_clr, cnt_en, cnt_term;

    step_counter #(.Word_Length(Word_Length)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (step),
        .term  (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_regs = (state == LOAD);
        shift_en  = (state == RUN);
        add_en    = (state == RUN) && mplr_lsb;
        ready     = (state == IDLE);
        busy      = (state == LOAD) || (state == RUN);
        done      = (state == DONE);
        // Abort zeroes the step as well, so an interrupted run leaves no residue
        cnt_clr   = abort || (state == LOAD);
        cnt_en    = (state == RUN);

        case (state)
            IDLE:    if (start)    state_nxt = LOAD;
            LOAD:                  state_nxt = RUN;
            RUN:     if (cnt_term) state_nxt = DONE;
            DONE:    if (ack)      state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase

        // Abort in IDLE also suppresses a simultaneous start
        if (abort) state_nxt = IDLE;
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: expected LOAD/RUN/DONE output vectors are
// queued at stimulus time and popped by a monitor on every datapath event.
module tb_mult_sequencer;
    import mult_pkg::*;

    typedef struct packed {
        logic       ld;
        logic       add;
        logic       sh;
        logic       dn;
        logic [2:0] st;
    } vec_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic       start = 1'b0, abort = 1'b0, ack = 1'b0;
    logic       start5 = 1'b0, abort5 = 1'b0, ack5 = 1'b0;
    logic       mplr_lsb;
    logic       load_regs, add_en, shift_en, ready, busy, done;
    logic [2:0] step;
    logic       load5, add5, shift5, ready5, busy5, done5;
    logic [2:0] step5;
    logic [7:0] op = 8'hA5, m = 8'h00;

    vec_t exp_q[$];
    int   errs = 0, checks = 0;
    bit   armed = 1'b0;
    logic done_q = 1'b0;

    always #5 clk = ~clk;

    mult_sequencer #(.Word_Length(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .mplr_lsb(mplr_lsb), .load_regs(load_regs), .add_en(add_en),
        .shift_en(shift_en), .step(step), .ready(ready), .busy(busy), .done(done)
    );

    mult_sequencer #(.Word_Length(5)) u5 (
        .clk(clk), .reset(reset), .start(start5), .abort(abort5), .ack(ack5),
        .mplr_lsb(mplr_lsb), .load_regs(load5), .add_en(add5),
        .shift_en(shift5), .step(step5), .ready(ready5), .busy(busy5), .done(done5)
    );

    // Minimal multiplier shift register feeding mplr_lsb
    always @(posedge clk) begin
        if (load_regs)     m <= op;
        else if (shift_en) m <= m >> 1;
    end
    assign mplr_lsb = m[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // addpat: expected add_en per RUN step, LSB = step 0
    task automatic push_run(input logic [7:0] addpat, input int nrun, input bit with_done);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        for (int k = 0; k < nrun; k++)
            exp_q.push_back({1'b0, addpat[k], 1'b1, 1'b0, 3'(k)});
        if (with_done) exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            n = i;
            if (done) break;
        end
    endtask

    always @(negedge clk) begin : mon
        vec_t got, want;
        if (armed) begin
            if (load_regs || shift_en || (done && !done_q)) begin
                got = {load_regs, add_en, shift_en, done, step};
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL scoreboard: unexpected event %0h, nothing queued", got);
                end else begin
                    want = exp_q.pop_front();
                    chk("scoreboard", got, want);
                end
            end
            chk("onehot8", int'(ready) + int'(busy) + int'(done), 1);
            chk("onehot5", int'(ready5) + int'(busy5) + int'(done5), 1);
        end
        done_q = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;

        // Power-on reset
        tick; tick; tick;
        armed = 1'b1;
        chk("rst ready", ready, 1);
        chk("rst outs", {load_regs, add_en, shift_en, busy, done}, 0);
        chk("rst step", step, 0);
        reset = 1'b0;

        // Nominal run, multiplier 0xA5
        op = 8'hA5;
        push_run(8'hA5, 8, 1'b1);
        start = 1'b1; tick; start = 1'b0;
        wait_done(n);
        chk("nominal latency", n, 9);

        // Hold done without ack; start must be ignored
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("done held", {done, load_regs}, 2'b10);
        end
        ack = 1'b1; tick; start = 1'b0; ack = 1'b0;
        chk("ack+start ready", ready, 1);
        chk("ack+start no load", load_regs, 0);
        chk("ack+start state", u8.state, IDLE);
        tick;
        chk("idle after ack", {ready, load_regs}, 2'b10);

        // Abort at step 3
        push_run(8'hA5, 4, 1'b0);
        start = 1'b1; tick; start = 1'b0;
        repeat (4) tick;
        chk("abort at step", step, 3);
        abort = 1'b1; tick; abort = 1'b0;
        chk("abort ready", ready, 1);
        chk("abort step", step, 0);
        seen = 1'b0;
        repeat (15) begin
            tick;
            if (done) seen = 1'b1;
        end
        chk("abort no done", seen, 0);
        start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
        chk("start+abort idle", {ready, load_regs}, 2'b10);
        tick;
        chk("start+abort no load", {ready, load_regs}, 2'b10);

        // Back-to-back: ack on done, restart in the IDLE cycle
        push_run(8'hA5, 8, 1'b1);
        start = 1'b1; tick; start = 1'b0;
        wait_done(n);
        chk("b2b run1 latency", n, 9);
        ack = 1'b1; tick; ack = 1'b0;
        chk("b2b idle gap", {ready, load_regs}, 2'b10);
        op = 8'h3C;
        push_run(8'h3C, 8, 1'b1);
        start = 1'b1; tick; start = 1'b0;
        chk("b2b load 2 after done", load_regs, 1);
        wait_done(n);
        chk("b2b run2 latency", n, 9);
        chk("b2b step wrap", step, 0);
        ack = 1'b1; tick; ack = 1'b0;

        // Reset mid-RUN
        op = 8'hA5;
        push_run(8'hA5, 3, 1'b0);
        start = 1'b1; tick; start = 1'b0;
        tick; tick; tick;
        chk("pre-reset step", step, 2);
        reset = 1'b1; tick;
        chk("midrun rst ready", ready, 1);
        chk("midrun rst outs", {load_regs, add_en, shift_en, busy, done}, 0);
        chk("midrun rst step", step, 0);
        chk("midrun rst state", u8.state, IDLE);
        tick; tick; reset = 1'b0; tick;
        chk("post-reset idle", {ready, done}, 2'b10);

        // Non-power-of-2 length
        start5 = 1'b1; tick; start5 = 1'b0;
        chk("wl5 load", load5, 1);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("wl5 step", {shift5, step5}, {1'b1, 3'(k)});
        end
        tick;
        chk("wl5 done", {done5, step5}, {1'b1, 3'd0});
        ack5 = 1'b1; tick; ack5 = 1'b0;
        chk("wl5 idle", ready5, 1);

        repeat (3) tick;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
